// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO read-side egress stage: buffer occupancy
// encoding and default widths.
package fifo_rd_pkg;

  localparam int DEF_DSIZE = 8;
  localparam int DEF_CNT_W = 16;

  // Encoding 2'd3 is never entered; the FSM steers it back to ST_EMPTY.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Bundles the FIFO read port and the valid/ready output stream of the
// egress stage. master = egress stage side, slave = FIFO/sink side.
// With FIFO_RD_STATS_EN defined the rd_count statistics signal is added.
interface fifo_rd_stream_if
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int CNT_W = DEF_CNT_W
);

  logic             fifo_rempty;
  logic [DSIZE-1:0] fifo_rdata;
  logic             fifo_rinc;
  logic             m_valid;
  logic             m_ready;
  logic [DSIZE-1:0] m_data;
`ifdef FIFO_RD_STATS_EN
  logic [CNT_W-1:0] rd_count;
`endif

  modport master (
    input  fifo_rempty,
    input  fifo_rdata,
    output fifo_rinc,
    output m_valid,
    input  m_ready,
    output m_data
`ifdef FIFO_RD_STATS_EN
    , output rd_count
`endif
  );

  modport slave (
    output fifo_rempty,
    output fifo_rdata,
    input  fifo_rinc,
    input  m_valid,
    output m_ready,
    input  m_data
`ifdef FIFO_RD_STATS_EN
    , input rd_count
`endif
  );

endinterface

// File: rtl/fifo_rd_sat_cnt.sv
// CNT_W-bit up-counter that sticks at its all-ones value instead of wrapping.
module fifo_rd_sat_cnt
  import fifo_rd_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_r;

  // Count increments, holding once the maximum value is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side egress stage behind the async FIFO. Turns the FIFO's
// rinc/rempty/rdata port into a valid/ready stream using a two-entry
// output + skid buffer, so pops and outputs depend only on registered state.
// Optional statistics counter (rd_count) enabled by macro FIFO_RD_STATS_EN.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              rclk,
  input  logic              rrst_n,
  fifo_rd_stream_if.master  bus
);

  state_e           state_r;
  state_e           next_state_s;
  logic [DSIZE-1:0] out_r;
  logic [DSIZE-1:0] skid_r;
  logic             take_s;
  logic             valid_s;
  logic             fire_s;
  logic             load_out_s;
  logic             out_from_skid_s;
  logic             load_skid_s;

  // Pop decision uses only the registered empty flag and the state register.
  assign take_s = ~bus.fifo_rempty & (state_r != ST_TWO);
  assign fire_s = valid_s & bus.m_ready;

  // State register: buffer occupancy.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: occupancy change from pop (take) and accept (fire).
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (take_s) next_state_s = ST_ONE;
        else        next_state_s = ST_EMPTY;
      end
      ST_ONE: begin
        if (take_s && !fire_s)      next_state_s = ST_TWO;
        else if (!take_s && fire_s) next_state_s = ST_EMPTY;
        else                        next_state_s = ST_ONE;
      end
      ST_TWO: begin
        if (fire_s) next_state_s = ST_ONE;
        else        next_state_s = ST_TWO;
      end
      default: next_state_s = ST_EMPTY;
    endcase
  end

  // Output/control decode: valid flag and which buffer register loads.
  always_comb begin
    valid_s         = (state_r != ST_EMPTY);
    load_out_s      = 1'b0;
    out_from_skid_s = 1'b0;
    load_skid_s     = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (take_s) load_out_s = 1'b1;
        else        load_out_s = 1'b0;
      end
      ST_ONE: begin
        // Pop with accept replaces the head; pop without accept parks in skid.
        if (take_s && fire_s)       load_out_s  = 1'b1;
        else if (take_s && !fire_s) load_skid_s = 1'b1;
        else                        load_out_s  = 1'b0;
      end
      ST_TWO: begin
        if (fire_s) begin
          load_out_s      = 1'b1;
          out_from_skid_s = 1'b1;
        end else begin
          load_out_s = 1'b0;
        end
      end
      default: begin
        load_out_s = 1'b0;
      end
    endcase
  end

  // Data registers: output word and skid word.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      out_r  <= {DSIZE{1'b0}};
      skid_r <= {DSIZE{1'b0}};
    end else begin
      if (load_out_s) begin
        out_r <= out_from_skid_s ? skid_r : bus.fifo_rdata;
      end else begin
        out_r <= out_r;
      end
      if (load_skid_s) begin
        skid_r <= bus.fifo_rdata;
      end else begin
        skid_r <= skid_r;
      end
    end
  end

  assign bus.fifo_rinc = take_s;
  assign bus.m_valid   = valid_s;
  assign bus.m_data    = out_r;

`ifdef FIFO_RD_STATS_EN
  fifo_rd_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_sat_cnt (
    .clk   (rclk),
    .rst_n (rrst_n),
    .inc   (fire_s),
    .count (bus.rd_count)
  );
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream. A queue models the FIFO contents;
// every word written to it is expected at the output, in order.
module tb_fifo_rd_stream;
  import fifo_rd_pkg::*;

  localparam int TB_CNT_W = 4;

  logic rclk;
  logic rrst_n;

  fifo_rd_stream_if #(.DSIZE(8), .CNT_W(TB_CNT_W)) bus ();

  fifo_rd_stream #(.DSIZE(8), .CNT_W(TB_CNT_W)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         pop_cnt;
  int         fire_cnt;
  logic       valid_pre;
  logic       ready_pre;
  logic [7:0] data_pre;

  task automatic drive_fifo();
    bus.fifo_rempty = (fifo_q.size() == 0);
    bus.fifo_rdata  = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    #1;
  endtask

  // Advance one clock; the FIFO model pops on rinc, the sink collects fires.
  task automatic tick();
    logic       rinc_p;
    logic       fire_p;
    logic [7:0] dat_p;
    logic [7:0] dummy;
    #1;
    rinc_p    = bus.fifo_rinc;
    fire_p    = bus.m_valid & bus.m_ready;
    dat_p     = bus.m_data;
    valid_pre = bus.m_valid;
    ready_pre = bus.m_ready;
    data_pre  = dat_p;
    @(posedge rclk);
    #1;
    if (rrst_n) begin
      if (rinc_p && fifo_q.size() > 0) begin
        dummy = fifo_q.pop_front();
        pop_cnt++;
      end
      if (fire_p) begin
        got_q.push_back(dat_p);
        fire_cnt++;
      end
    end
    drive_fifo();
  endtask

  task automatic apply_reset();
    rrst_n = 1'b0;
    fifo_q.delete();
    got_q.delete();
    exp_q.delete();
    pop_cnt  = 0;
    fire_cnt = 0;
    drive_fifo();
    repeat (3) tick();
    rrst_n = 1'b1;
    drive_fifo();
  endtask

  task automatic test_reset();
    bus.m_ready = 1'b0;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.m_valid !== 1'b0 || bus.fifo_rinc !== 1'b0 || bus.m_data !== 8'h00) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: valid=%b rinc=%b data=%h expected 0 0 00",
                 i, bus.m_valid, bus.fifo_rinc, bus.m_data);
      end
      tick();
    end
  endtask

  task automatic test_stream();
    logic [7:0] w [3];
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
    got_q.delete();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 3; i++) fifo_q.push_back(w[i]);
    drive_fifo();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.fifo_rinc !== 1'b1) begin
        errors++;
        $display("FAIL stream_rinc %0d: got %b expected 1", i, bus.fifo_rinc);
      end
      tick();
      checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== w[i]) begin
        errors++;
        $display("FAIL stream_data %0d: valid=%b data=%h expected 1 %h", i, bus.m_valid, bus.m_data, w[i]);
      end
    end
    checks++;
    if (bus.fifo_rinc !== 1'b0) begin
      errors++;
      $display("FAIL stream_rinc_end: got %b expected 0", bus.fifo_rinc);
    end
    tick();
    checks++;
    if (bus.m_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain_valid: got %b expected 0", bus.m_valid);
    end
    checks++;
    if (got_q.size() != 3 || got_q[0] !== 8'h11 || got_q[1] !== 8'h22 || got_q[2] !== 8'h33) begin
      errors++;
      $display("FAIL stream_order: got %0d words expected 11 22 33", got_q.size());
    end
  endtask

  task automatic test_backpressure();
    got_q.delete();
    pop_cnt  = 0;
    fire_cnt = 0;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) fifo_q.push_back(8'hA0 + 8'(i));
    drive_fifo();
    repeat (4) tick();
    checks++;
    if (pop_cnt != 2 || fifo_q.size() != 3) begin
      errors++;
      $display("FAIL bp_pops: got %0d pops expected 2", pop_cnt);
    end
    checks++;
    if (bus.fifo_rinc !== 1'b0 || dut.state_r !== 2'd2) begin
      errors++;
      $display("FAIL bp_full: rinc=%b state=%0d expected 0 2", bus.fifo_rinc, dut.state_r);
    end
    checks++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 8'hA0) begin
      errors++;
      $display("FAIL bp_hold: valid=%b data=%h expected 1 a0", bus.m_valid, bus.m_data);
    end
    bus.m_ready = 1'b1;
    for (int c = 0; c < 20 && got_q.size() < 5; c++) tick();
    checks++;
    if (got_q.size() != 5) begin
      errors++;
      $display("FAIL bp_count: got %0d words expected 5", got_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got_q[i] !== 8'hA0 + 8'(i)) begin
          errors++;
          $display("FAIL bp_order %0d: got %h expected %h", i, got_q[i], 8'hA0 + 8'(i));
        end
      end
    end
    tick();
  endtask

  task automatic test_random();
    int pushed = 0;
    int cyc    = 0;
    logic [7:0] wv;
    got_q.delete();
    exp_q.delete();
    pop_cnt  = 0;
    fire_cnt = 0;
    while (got_q.size() < 200 && cyc < 5000) begin
      if (pushed < 200 && $urandom_range(0, 2) != 0) begin
        wv = 8'($urandom);
        fifo_q.push_back(wv);
        exp_q.push_back(wv);
        pushed++;
      end
      drive_fifo();
      bus.m_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
      if (valid_pre && !ready_pre) begin
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== data_pre) begin
          errors++;
          $display("FAIL rand_stable cyc %0d: valid=%b data=%h expected 1 %h", cyc, bus.m_valid, bus.m_data, data_pre);
        end
      end
      checks++;
      if ((pop_cnt - fire_cnt) > 2 || bus.m_valid !== (pop_cnt != fire_cnt)) begin
        errors++;
        $display("FAIL rand_occupancy cyc %0d: held=%0d valid=%b", cyc, pop_cnt - fire_cnt, bus.m_valid);
      end
    end
    checks++;
    if (got_q.size() != 200) begin
      errors++;
      $display("FAIL rand_timeout: got %0d words expected 200", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_order %0d: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    bus.m_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) fifo_q.push_back(8'hC0 + 8'(i));
    drive_fifo();
    repeat (3) tick();
    checks++;
    if (bus.m_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: valid=%b expected 1", bus.m_valid);
    end
    #2;
    rrst_n = 1'b0;
    #1;
    checks++;
    if (bus.m_valid !== 1'b0 || bus.m_data !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_async: valid=%b data=%h expected 0 00", bus.m_valid, bus.m_data);
    end
    fifo_q.delete();
    drive_fifo();
    tick();
    rrst_n = 1'b1;
    got_q.delete();
    drive_fifo();
    tick();
    checks++;
    if (bus.m_valid !== 1'b0 || bus.fifo_rinc !== 1'b0 || bus.m_data !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_after: valid=%b rinc=%b data=%h expected 0 0 00", bus.m_valid, bus.fifo_rinc, bus.m_data);
    end
    bus.m_ready = 1'b1;
    fifo_q.push_back(8'h5A);
    drive_fifo();
    tick();
    checks++;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h5A) begin
      errors++;
      $display("FAIL rstmid_fresh: valid=%b data=%h expected 1 5a", bus.m_valid, bus.m_data);
    end
    repeat (2) tick();
  endtask

`ifdef FIFO_RD_STATS_EN
  task automatic test_stats();
    bus.m_ready = 1'b0;
    apply_reset();
    checks++;
    if (bus.rd_count !== 4'd0) begin
      errors++;
      $display("FAIL stats_init: got %0d expected 0", bus.rd_count);
    end
    bus.m_ready = 1'b1;
    for (int i = 0; i < 20; i++) fifo_q.push_back(8'(i));
    drive_fifo();
    for (int c = 0; c < 60 && fire_cnt < 20; c++) tick();
    checks++;
    if (fire_cnt != 20 || bus.rd_count !== 4'd15) begin
      errors++;
      $display("FAIL stats_sat: fires=%0d count=%0d expected 20 15", fire_cnt, bus.rd_count);
    end
    rrst_n = 1'b0;
    #1;
    checks++;
    if (bus.rd_count !== 4'd0) begin
      errors++;
      $display("FAIL stats_reset: got %0d expected 0", bus.rd_count);
    end
    rrst_n = 1'b1;
    tick();
  endtask
`endif

  initial begin
    rrst_n      = 1'b0;
    bus.m_ready = 1'b0;
    pop_cnt     = 0;
    fire_cnt    = 0;
    drive_fifo();
    test_reset();
    test_stream();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef FIFO_RD_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
